// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC interval path.
// Holds the FSM state encoding, a width helper and the fine-bin count
// shared with the start/stop decoder instances.
package tdc_pkg;

  // Number of fine bins spanning one clock period, shared with the decoders.
  localparam int NUM_BINS_DEF = 200;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    RUN   = ST_RUN,
    CALC  = ST_CALC,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to hold the values 0 .. value-1 (minimum 1).
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/tdc_interval_calc.sv
// Combinational interval arithmetic: coarse*NUM_BINS + start - stop.
// Evaluated in signed arithmetic two bits wider than the result so nothing
// is lost before the sign test; negative results clamp to 0 with an error flag.
// Ports:
//   coarse_i    coarse cycle count
//   start_bin_i start fine bin
//   stop_bin_i  stop fine bin
//   interval_o  interval in fine bins (clamped, truncated to BITS_RES)
//   error_o     high when the exact result was negative
module tdc_interval_calc
  import tdc_pkg::*;
#(
  parameter int BITS_DECO   = 8,
  parameter int BITS_COARSE = 16,
  parameter int NUM_BINS    = NUM_BINS_DEF,
  parameter int BITS_RES    = 24
) (
  input  logic [BITS_COARSE-1:0] coarse_i,
  input  logic [BITS_DECO-1:0]   start_bin_i,
  input  logic [BITS_DECO-1:0]   stop_bin_i,
  output logic [BITS_RES-1:0]    interval_o,
  output logic                   error_o
);

  localparam int W    = BITS_RES + 2;
  localparam int NB_W = clog2w(NUM_BINS + 1);

  logic signed [W-1:0] coarse_s;
  logic signed [W-1:0] start_s;
  logic signed [W-1:0] stop_s;
  logic signed [W-1:0] nbins_s;
  logic signed [W-1:0] sum_s;
  logic                unused_hi;

  // Zero-extend everything into the wide signed domain.
  assign coarse_s = $signed({{(W-BITS_COARSE){1'b0}}, coarse_i});
  assign start_s  = $signed({{(W-BITS_DECO){1'b0}}, start_bin_i});
  assign stop_s   = $signed({{(W-BITS_DECO){1'b0}}, stop_bin_i});
  assign nbins_s  = $signed({{(W-NB_W){1'b0}}, NB_W'(NUM_BINS)});

  assign sum_s = coarse_s * nbins_s + start_s - stop_s;

  assign error_o    = sum_s[W-1];
  assign interval_o = sum_s[W-1] ? '0 : sum_s[BITS_RES-1:0];

  // Bits above the result width are discarded by design.
  assign unused_hi = ^sum_s[W-2:BITS_RES];

endmodule

// File: rtl/tdc_interval_builder.sv
// Builds one start-to-stop interval (in fine bins) per armed shot from the
// start/stop decoder bin numbers and a coarse cycle counter, and hands the
// result to the readout stage over valid/ready.
// Ports:
//   wClk, wRst            clock, asynchronous active-high reset
//   wArm                  one-cycle arm request (honoured only when idle)
//   wStartHit/wStartBin   start decoder hit and fine bin
//   wStopHit/wStopBin     stop decoder hit and fine bin
//   wInterval, wCoarse    result interval and raw coarse count
//   wTimeout, wError      result flags, meaningful while wValid is high
//   wValid, wReady        result handshake
//   wBusy                 high whenever a shot is in progress or pending
module tdc_interval_builder
  import tdc_pkg::*;
#(
  parameter int BITS_DECO   = 8,
  parameter int BITS_COARSE = 16,
  parameter int NUM_BINS    = NUM_BINS_DEF,
  parameter int MAX_COARSE  = 65535,
  parameter int BITS_RES    = 24
) (
  input  logic                   wClk,
  input  logic                   wRst,
  input  logic                   wArm,
  input  logic                   wStartHit,
  input  logic [BITS_DECO-1:0]   wStartBin,
  input  logic                   wStopHit,
  input  logic [BITS_DECO-1:0]   wStopBin,
  output logic [BITS_RES-1:0]    wInterval,
  output logic [BITS_COARSE-1:0] wCoarse,
  output logic                   wTimeout,
  output logic                   wError,
  output logic                   wValid,
  input  logic                   wReady,
  output logic                   wBusy
);

  localparam logic [BITS_COARSE-1:0] MAX_C = BITS_COARSE'(MAX_COARSE);

  state_t                 state_q;
  logic [BITS_DECO-1:0]   start_bin_q;
  logic [BITS_DECO-1:0]   stop_bin_q;
  logic [BITS_COARSE-1:0] coarse_q;
  logic [BITS_COARSE-1:0] coarse_d;
  logic [BITS_RES-1:0]    interval_q;
  logic [BITS_COARSE-1:0] coarse_out_q;
  logic                   timeout_q;
  logic                   error_q;
  logic                   valid_q;

  logic [BITS_RES-1:0]    calc_interval;
  logic                   calc_error;

  assign coarse_d = coarse_q + BITS_COARSE'(1);

  tdc_interval_calc #(
    .BITS_DECO  (BITS_DECO),
    .BITS_COARSE(BITS_COARSE),
    .NUM_BINS   (NUM_BINS),
    .BITS_RES   (BITS_RES)
  ) u_calc (
    .coarse_i   (coarse_q),
    .start_bin_i(start_bin_q),
    .stop_bin_i (stop_bin_q),
    .interval_o (calc_interval),
    .error_o    (calc_error)
  );

  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      state_q      <= IDLE;
      start_bin_q  <= '0;
      stop_bin_q   <= '0;
      coarse_q     <= '0;
      interval_q   <= '0;
      coarse_out_q <= '0;
      timeout_q    <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wArm) state_q <= ARMED;
        end

        ARMED: begin
          if (wStartHit) begin
            start_bin_q <= wStartBin;
            // A same-cycle stop only counts if it cannot precede the start
            // inside this clock period; otherwise it belongs to noise.
            if (wStopHit && (wStopBin <= wStartBin)) begin
              stop_bin_q <= wStopBin;
              coarse_q   <= '0;
              state_q    <= CALC;
            end else begin
              coarse_q <= BITS_COARSE'(1);
              state_q  <= RUN;
            end
          end
        end

        RUN: begin
          // A stop in the cycle the counter reaches its limit still wins.
          if (wStopHit) begin
            stop_bin_q <= wStopBin;
            state_q    <= CALC;
          end else if (coarse_q == MAX_C) begin
            interval_q   <= '1;
            coarse_out_q <= MAX_C;
            timeout_q    <= 1'b1;
            error_q      <= 1'b0;
            valid_q      <= 1'b1;
            state_q      <= DONE;
          end else begin
            coarse_q <= coarse_d;
          end
        end

        CALC: begin
          interval_q   <= calc_interval;
          error_q      <= calc_error;
          timeout_q    <= 1'b0;
          coarse_out_q <= coarse_q;
          valid_q      <= 1'b1;
          state_q      <= DONE;
        end

        DONE: begin
          if (valid_q && wReady) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wInterval = interval_q;
  assign wCoarse   = coarse_out_q;
  assign wTimeout  = timeout_q;
  assign wError    = error_q;
  assign wValid    = valid_q;
  assign wBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_interval_builder.sv
module tb_tdc_interval_builder;

  localparam int BITS_DECO   = 8;
  localparam int BITS_COARSE = 16;
  localparam int NUM_BINS    = 200;
  localparam int MAX_C       = 20;
  localparam int BITS_RES    = 24;

  logic                   wClk = 1'b0;
  logic                   wRst = 1'b0;
  logic                   wArm = 1'b0;
  logic                   wStartHit = 1'b0;
  logic [BITS_DECO-1:0]   wStartBin = '0;
  logic                   wStopHit = 1'b0;
  logic [BITS_DECO-1:0]   wStopBin = '0;
  logic [BITS_RES-1:0]    wInterval;
  logic [BITS_COARSE-1:0] wCoarse;
  logic                   wTimeout;
  logic                   wError;
  logic                   wValid;
  logic                   wReady = 1'b0;
  logic                   wBusy;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [BITS_RES-1:0]    iv;
    logic [BITS_COARSE-1:0] co;
    logic                   to;
    logic                   er;
    int                     cyc;
  } exp_t;

  exp_t exp_q[$];

  tdc_interval_builder #(
    .BITS_DECO  (BITS_DECO),
    .BITS_COARSE(BITS_COARSE),
    .NUM_BINS   (NUM_BINS),
    .MAX_COARSE (MAX_C),
    .BITS_RES   (BITS_RES)
  ) dut (
    .wClk     (wClk),
    .wRst     (wRst),
    .wArm     (wArm),
    .wStartHit(wStartHit),
    .wStartBin(wStartBin),
    .wStopHit (wStopHit),
    .wStopBin (wStopBin),
    .wInterval(wInterval),
    .wCoarse  (wCoarse),
    .wTimeout (wTimeout),
    .wError   (wError),
    .wValid   (wValid),
    .wReady   (wReady),
    .wBusy    (wBusy)
  );

  always #5 wClk = ~wClk;
  always @(posedge wClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge wClk);
    #1;
  endtask

  task automatic clr();
    wArm = 1'b0; wStartHit = 1'b0; wStopHit = 1'b0;
  endtask

  task automatic noise(input bit allow_start, input bit allow_stop, input bit allow_arm);
    wStartHit = allow_start && ($urandom_range(0, 2) == 0);
    wStartBin = 8'($urandom_range(0, NUM_BINS - 1));
    wStopHit  = allow_stop && ($urandom_range(0, 2) == 0);
    wStopBin  = 8'($urandom_range(0, NUM_BINS - 1));
    wArm      = allow_arm && ($urandom_range(0, 2) == 0);
  endtask

  // Reference: interval = coarse*NUM_BINS + start - stop, clamped at 0.
  // A same-cycle stop counts only if its bin does not exceed the start bin;
  // otherwise the first later stop at k cycles after the start gives coarse=k;
  // with no stop by MAX_C cycles the shot times out.
  function automatic exp_t model(input int sbin, input bit same_hit, input int same_bin,
                                 input int k, input int pbin);
    exp_t e;
    int   v;
    e.to = 1'b0; e.er = 1'b0; e.cyc = 0; e.iv = '0; e.co = '0;
    if (same_hit && same_bin <= sbin) begin
      v = sbin - same_bin;
      e.co = '0;
    end else if (k <= MAX_C) begin
      v = k * NUM_BINS + sbin - pbin;
      e.co = 16'(k);
    end else begin
      e.iv = {BITS_RES{1'b1}};
      e.co = 16'(MAX_C);
      e.to = 1'b1;
      return e;
    end
    if (v < 0) begin
      e.iv = '0; e.er = 1'b1;
    end else begin
      e.iv = 24'(v);
    end
    return e;
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = never ready.
  initial begin
    forever begin
      @(posedge wClk);
      #1;
      case (rdy_mode)
        0: wReady = 1'b1;
        1: wReady = 1'($urandom_range(0, 1));
        default: wReady = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expectation per presented result, then checks that
  // the result stays stable until it is accepted.
  exp_t cur;
  bit   have_cur = 1'b0;
  always @(negedge wClk) begin
    if (wRst) begin
      have_cur = 1'b0;
    end else if (wValid) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got wValid=1 with interval %0d, required no pending result (cycle %0d)", wInterval, cyc);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("interval", wInterval, cur.iv);
          check("coarse", wCoarse, cur.co);
          check("timeout", wTimeout, cur.to);
          check("error", wError, cur.er);
          check("valid_cycle", cyc, cur.cyc);
        end
      end else begin
        check("hold_interval", wInterval, cur.iv);
        check("hold_coarse", wCoarse, cur.co);
        check("hold_flags", {wTimeout, wError}, {cur.to, cur.er});
      end
      if (wReady) have_cur = 1'b0;
    end
  end

  task automatic run_shot(input int sdel, input int sbin, input bit same_hit, input int same_bin,
                          input int k, input int pbin, input int rmode, input int hold,
                          input bit wait_idle);
    exp_t e;
    int   seen;
    int   t;
    rdy_mode = rmode;
    e = model(sbin, same_hit, same_bin, k, pbin);
    wArm = 1'b1;
    tick();
    wArm = 1'b0;
    for (int i = 0; i < sdel; i++) begin
      noise(1'b0, 1'b1, 1'b1);
      tick();
    end
    clr();
    wStartHit = 1'b1; wStartBin = 8'(sbin);
    wStopHit = same_hit; wStopBin = 8'(same_bin);
    tick();
    clr();
    if (same_hit && same_bin <= sbin) begin
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end else begin
      for (int j = 1; j <= MAX_C; j++) begin
        if (j == k) begin
          wStopHit = 1'b1; wStopBin = 8'(pbin);
        end else begin
          noise(1'b1, 1'b0, 1'b1);
        end
        tick();
        clr();
        if (j == k) break;
      end
      e.cyc = (k <= MAX_C) ? cyc + 1 : cyc;
      exp_q.push_back(e);
    end
    if (wait_idle) begin
      seen = 0;
      t = 0;
      while (wBusy && t < 200) begin
        if (wValid) seen++;
        if (hold > 0 && seen >= hold) rdy_mode = 0;
        noise(1'b1, 1'b1, 1'b1);
        tick();
        t++;
      end
      clr();
      check("return_idle", wBusy, 0);
      tick();
      check("accept_arm_dropped", wBusy, 0);
    end
  endtask

  task automatic check_reset_state(input string name);
    check(name, {wInterval, wCoarse, wTimeout, wError, wValid, wBusy}, 0);
  endtask

  task automatic post_reset_quiet();
    tick();
    wRst = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      noise(1'b1, 1'b1, 1'b0);
      tick();
    end
    clr();
    check("no_result_after_reset", {wValid, wBusy}, 0);
  endtask

  initial begin
    #2;
    wRst = 1'b1;
    #1;
    check_reset_state("reset_state");
    tick();
    tick();
    wRst = 1'b0;
    tick();

    run_shot(0, 150, 1'b0, 0, 2, 30, 0, 0, 1'b1);        // 520, coarse 2
    run_shot(1, 120, 1'b1, 40, 5, 0, 0, 0, 1'b1);        // same cycle: 80, coarse 0
    run_shot(0, 120, 1'b1, 160, 1, 160, 0, 0, 1'b1);     // same-cycle stop ignored: 160
    run_shot(0, 10, 1'b0, 0, 1, 199, 0, 0, 1'b1);        // 200+10-199 = 11
    run_shot(0, 0, 1'b0, 0, 3, 0, 0, 0, 1'b1);           // bin 0 is a real bin: 600
    run_shot(0, 199, 1'b1, 199, 4, 0, 0, 0, 1'b1);       // equal bins same cycle: 0
    run_shot(0, 50, 1'b0, 0, MAX_C + 5, 0, 0, 0, 1'b1);  // timeout
    run_shot(0, 50, 1'b0, 0, MAX_C, 0, 0, 0, 1'b1);      // stop at the limit: 4050
    run_shot(2, 60, 1'b0, 0, 4, 90, 2, 10, 1'b1);        // held 10 cycles: 770

    // Reset while running.
    rdy_mode = 0;
    wArm = 1'b1; tick(); wArm = 1'b0;
    wStartHit = 1'b1; wStartBin = 8'd77; tick(); clr();
    tick(); tick();
    wRst = 1'b1;
    #1;
    check_reset_state("reset_in_run");
    post_reset_quiet();
    run_shot(0, 30, 1'b0, 0, 3, 100, 0, 0, 1'b1);        // 530

    // Reset while a result is pending.
    run_shot(0, 100, 1'b0, 0, 3, 50, 2, 0, 1'b0);        // 650, never accepted
    tick(); tick(); tick();
    wRst = 1'b1;
    #1;
    check_reset_state("reset_in_done");
    post_reset_quiet();
    run_shot(1, 5, 1'b0, 0, 1, 6, 0, 0, 1'b1);           // 199

    for (int n = 0; n < 40; n++) begin
      run_shot($urandom_range(0, 3), $urandom_range(0, NUM_BINS - 1),
               1'($urandom_range(0, 3) == 0), $urandom_range(0, NUM_BINS - 1),
               $urandom_range(1, MAX_C + 2), $urandom_range(0, NUM_BINS - 1),
               $urandom_range(0, 1), 0, 1'b1);
    end

    repeat (5) tick();
    check("results_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time %0t, required bench to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
